// File: rtl/csr_redirect_ctrl_pkg.sv
// Shared definitions for the CSR redirect controller: exception codes, FSM state encoding
// and the flush-count helper. Both exception macros can be overridden from the command line.
`ifndef EXCEPTION_W
`define EXCEPTION_W 6
`endif
`ifndef EXCEPTION_FENCE
`define EXCEPTION_FENCE 6'd24
`endif

package csr_redirect_ctrl_pkg;

  localparam int EXC_W = `EXCEPTION_W;

  typedef enum logic [1:0] {
    CSR_RDR_IDLE     = 2'd0,
    CSR_RDR_FLUSH    = 2'd1,
    CSR_RDR_INVAL    = 2'd2,
    CSR_RDR_REDIRECT = 2'd3
  } csr_rdr_state_t;

  // The flush timer holds "cycles remaining minus one", so a load of n-1 yields n FLUSH cycles.
  function automatic logic [3:0] flush_load_val(input int cycles);
    return 4'(cycles - 1);
  endfunction

endpackage

// File: rtl/csr_redirect_ctrl_if.sv
// Bus between the CSR/exception stage, fetch, the I-cache and the redirect controller.
// The master modport is the controller; the slave modport is its environment.
interface csr_redirect_ctrl_if #(
  parameter int PC_W = 32
);

  logic                    valid_i;
  logic [PC_W-1:0]         pc_i;
  logic [`EXCEPTION_W-1:0] exception_i;
  logic                    csr_branch_i;
  logic [PC_W-1:0]         csr_target_i;
  logic                    icache_inv_done_i;
  logic                    stall_o;
  logic                    flush_o;
  logic                    icache_inv_o;
  // Redirect channel: a transfer occurs on any rising clock edge where redirect_valid_o and
  // redirect_ready_i are both high. Once valid is raised, it and redirect_pc_o hold steady
  // until that transfer occurs. Ready may be high at any time, and it is meaningless while
  // valid is low.
  logic                    redirect_valid_o;
  logic                    redirect_ready_i;
  logic [PC_W-1:0]         redirect_pc_o;
  logic [31:0]             trap_count_o;

  modport master (
    input  valid_i, pc_i, exception_i, csr_branch_i, csr_target_i,
           icache_inv_done_i, redirect_ready_i,
    output stall_o, flush_o, icache_inv_o, redirect_valid_o, redirect_pc_o, trap_count_o
  );

  modport slave (
    output valid_i, pc_i, exception_i, csr_branch_i, csr_target_i,
           icache_inv_done_i, redirect_ready_i,
    input  stall_o, flush_o, icache_inv_o, redirect_valid_o, redirect_pc_o, trap_count_o
  );

endinterface

// File: rtl/csr_flush_timer.sv
// Loadable 4-bit down-counter. It times the FLUSH phase, and its zero flag ends the phase.
module csr_flush_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/csr_redirect_ctrl.sv
// Pipeline recovery sequencer: flush, an optional I-cache invalidate for FENCE.I, then a
// redirect to fetch. Define CSR_REDIRECT_TRAP_CNT_EN to build the completed-redirect counter.
module csr_redirect_ctrl
  import csr_redirect_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int PC_W         = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  csr_redirect_ctrl_if.master  bus,
  output logic [1:0]           dbg_state
);

  if ((FLUSH_CYCLES < 1) || (FLUSH_CYCLES > 15)) begin : g_bad_flush_cycles
    $error("csr_redirect_ctrl: FLUSH_CYCLES must be in 1..15");
  end

  csr_rdr_state_t  state_q, state_d;
  logic            is_fence_q;
  logic [PC_W-1:0] redirect_pc_q;
  logic            is_fence_evt;
  logic            take_w;
  logic            hs_w;
  logic            flush_zero;
  logic            unused_target_lsbs;

  assign is_fence_evt = (bus.exception_i == `EXCEPTION_FENCE);
  assign take_w = (state_q == CSR_RDR_IDLE) & bus.valid_i & (is_fence_evt | bus.csr_branch_i);
  assign hs_w   = bus.redirect_valid_o & bus.redirect_ready_i;

  // Trap vectors and xEPC values are word aligned, so the low target bits are discarded.
  assign unused_target_lsbs = ^bus.csr_target_i[1:0];

  csr_flush_timer u_flush_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (take_w),
    .load_val (flush_load_val(FLUSH_CYCLES)),
    .dec      (state_q == CSR_RDR_FLUSH),
    .zero     (flush_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CSR_RDR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CSR_RDR_IDLE:     if (take_w) state_d = CSR_RDR_FLUSH;
      CSR_RDR_FLUSH:    if (flush_zero) state_d = is_fence_q ? CSR_RDR_INVAL : CSR_RDR_REDIRECT;
      CSR_RDR_INVAL:    if (bus.icache_inv_done_i) state_d = CSR_RDR_REDIRECT;
      CSR_RDR_REDIRECT: if (hs_w) state_d = CSR_RDR_IDLE;
      default:          state_d = CSR_RDR_IDLE;
    endcase
  end

  // Every control output is decoded from the registered state, so none of them glitch on
  // upstream inputs. The exception is stall_o, which must cover the event cycle itself.
  always_comb begin
    bus.flush_o          = (state_q == CSR_RDR_FLUSH);
    bus.icache_inv_o     = (state_q == CSR_RDR_INVAL);
    bus.redirect_valid_o = (state_q == CSR_RDR_REDIRECT);
    bus.stall_o          = take_w | (state_q != CSR_RDR_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_fence_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else if (take_w) begin
      is_fence_q    <= is_fence_evt;
      redirect_pc_q <= is_fence_evt ? (bus.pc_i + PC_W'(4))
                                    : {bus.csr_target_i[PC_W-1:2], 2'b00};
    end
  end

  assign bus.redirect_pc_o = redirect_pc_q;
  assign dbg_state         = state_q;

`ifdef CSR_REDIRECT_TRAP_CNT_EN
  logic [31:0] trap_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trap_count_q <= 32'd0;
    end else if (hs_w) begin
      trap_count_q <= trap_count_q + 32'd1;
    end
  end

  assign bus.trap_count_o = trap_count_q;
`else
  assign bus.trap_count_o = 32'h0;
`endif

endmodule

// File: tb/tb_csr_redirect_ctrl.sv
// Directed bench for csr_redirect_ctrl: a table of recovery events, plus hand-written
// reset-abort and counter sequences.
module tb_csr_redirect_ctrl;
  import csr_redirect_ctrl_pkg::*;

  localparam int FLUSH_CYCLES = 2;
  localparam int PC_W         = 32;
  localparam int EW           = `EXCEPTION_W;
  localparam logic [EW-1:0] EXC_FENCE = `EXCEPTION_FENCE;

  typedef struct {
    logic          valid;
    logic [EW-1:0] exc;
    logic          br;
    logic [31:0]   pc;
    logic [31:0]   tgt;
    int            done_dly;
    int            rdy_dly;
    bit            early;
    bit            inject;
    bit            exp_take;
    bit            exp_fence;
    logic [31:0]   exp_pc;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  csr_redirect_ctrl_if #(.PC_W(PC_W)) bus ();

  csr_redirect_ctrl #(
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .PC_W         (PC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_done   = 0;
  logic [31:0] exp_q[$];
  vec_t        vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic valid, input logic [EW-1:0] exc, input logic br,
                              input logic [31:0] pc, input logic [31:0] tgt,
                              input int done_dly, input int rdy_dly, input bit early,
                              input bit inject, input bit exp_take, input bit exp_fence,
                              input logic [31:0] exp_pc);
    vec_t v;
    v.valid = valid; v.exc = exc; v.br = br; v.pc = pc; v.tgt = tgt;
    v.done_dly = done_dly; v.rdy_dly = rdy_dly; v.early = early; v.inject = inject;
    v.exp_take = exp_take; v.exp_fence = exp_fence; v.exp_pc = exp_pc;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.valid_i           = 1'b0;
    bus.exception_i       = '0;
    bus.csr_branch_i      = 1'b0;
    bus.pc_i              = '0;
    bus.csr_target_i      = '0;
    bus.icache_inv_done_i = 1'b0;
  endtask

  // Called at a negedge (or just after one). It returns just after the negedge of the
  // first IDLE cycle, so back-to-back calls exercise back-to-back events.
  task automatic run_seq(input vec_t v);
    int fl  = 0;
    int inv = 0;
    int rv  = 0;
    int cyc = 0;
    bit done_seq = 1'b0;
    bus.valid_i          = v.valid;
    bus.exception_i      = v.exc;
    bus.csr_branch_i     = v.br;
    bus.pc_i             = v.pc;
    bus.csr_target_i     = v.tgt;
    bus.redirect_ready_i = 1'b0;
    bus.icache_inv_done_i = 1'b0;
    #1;
    check("stall_on_event", bus.stall_o, v.exp_take);
    if (v.exp_take) exp_q.push_back(v.exp_pc);
    @(negedge clk);
    drive_idle();
    if (!v.exp_take) begin
      #1;
      check("no_action_state", dbg_state, CSR_RDR_IDLE);
      check("no_action_flush", bus.flush_o, 1'b0);
      return;
    end
    while (!done_seq && cyc < 200) begin
      cyc++;
      case (dbg_state)
        CSR_RDR_FLUSH: begin
          fl++;
          bus.redirect_ready_i = v.early;
        end
        CSR_RDR_INVAL: begin
          inv++;
          check("inval_level", bus.icache_inv_o, 1'b1);
          bus.redirect_ready_i  = 1'b0;
          bus.icache_inv_done_i = (inv >= v.done_dly);
        end
        CSR_RDR_REDIRECT: begin
          rv++;
          bus.icache_inv_done_i = 1'b0;
          if (exp_q.size() > 0) check("redirect_pc", bus.redirect_pc_o, exp_q[0]);
          else check("redirect_unexpected", 32'd1, 32'd0);
          bus.redirect_ready_i = (rv > v.rdy_dly);
          if (v.inject) begin
            bus.valid_i      = 1'b1;
            bus.csr_branch_i = 1'b1;
            bus.csr_target_i = 32'h0BAD_0000;
          end
          if (bus.redirect_ready_i && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            n_done++;
          end
        end
        default: done_seq = 1'b1;
      endcase
      if (!done_seq) begin
        check("stall_busy", bus.stall_o, 1'b1);
        @(negedge clk);
      end
    end
    drive_idle();
    bus.redirect_ready_i = 1'b0;
    #1;
    if (!done_seq) check("seq_timeout", 32'd0, 32'd1);
    check("flush_cycles", fl, FLUSH_CYCLES);
    check("inval_cycles", inv, v.exp_fence ? v.done_dly : 0);
    check("redirect_cycles", rv, v.rdy_dly + 1);
    check("idle_flush_low", bus.flush_o, 1'b0);
    check("idle_stall_low", bus.stall_o, 1'b0);
  endtask

  task automatic check_count(input string name);
    logic [31:0] exp_cnt;
`ifdef CSR_REDIRECT_TRAP_CNT_EN
    exp_cnt = n_done;
`else
    exp_cnt = 32'd0;
`endif
    check(name, bus.trap_count_o, exp_cnt);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, dbg_state, CSR_RDR_IDLE);
    check({tag, "_stall"}, bus.stall_o, 1'b0);
    check({tag, "_flush"}, bus.flush_o, 1'b0);
    check({tag, "_inval"}, bus.icache_inv_o, 1'b0);
    check({tag, "_rvalid"}, bus.redirect_valid_o, 1'b0);
    check({tag, "_rpc"}, bus.redirect_pc_o, 32'h0);
    check({tag, "_count"}, bus.trap_count_o, 32'h0);
  endtask

  // ---------------- test ----------------
  initial begin
    int wait_cyc;
    vecs[0] = mk(1, '0, 1, 32'h0000_0100, 32'h8000_0103, 0, 0, 0, 0, 1, 0, 32'h8000_0100);
    vecs[1] = mk(1, EXC_FENCE, 0, 32'h0000_1FFC, 32'h0, 3, 0, 0, 0, 1, 1, 32'h0000_2000);
    vecs[2] = mk(1, '0, 1, 32'h0000_0200, 32'h0000_4002, 0, 5, 0, 1, 1, 0, 32'h0000_4000);
    vecs[3] = mk(1, EXC_FENCE, 0, 32'hFFFF_FFFC, 32'h0, 1, 0, 0, 0, 1, 1, 32'h0000_0000);
    vecs[4] = mk(1, EW'(2), 0, 32'h0000_0300, 32'h1111_1110, 0, 0, 0, 0, 0, 0, 32'h0);
    vecs[5] = mk(0, '0, 1, 32'h0000_0400, 32'h2222_2220, 0, 0, 0, 0, 0, 0, 32'h0);
    vecs[6] = mk(1, EXC_FENCE, 1, 32'h0000_0040, 32'h1234_5678, 1, 0, 0, 0, 1, 1, 32'h0000_0044);
    vecs[7] = mk(1, '0, 1, 32'h0000_0500, 32'hDEAD_BEEF, 0, 2, 1, 0, 1, 0, 32'hDEAD_BEEC);

    drive_idle();
    bus.redirect_ready_i = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_seq(vecs[i]);
    check("scoreboard_empty", exp_q.size(), 0);
    check_count("count_after_table");

    // Abort a FENCE sequence while it waits in INVAL.
    bus.valid_i     = 1'b1;
    bus.exception_i = EXC_FENCE;
    bus.pc_i        = 32'h0000_0500;
    @(negedge clk);
    drive_idle();
    wait_cyc = 0;
    while (dbg_state != CSR_RDR_INVAL && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("reach_inval", dbg_state, CSR_RDR_INVAL);
    check("inval_before_reset", bus.icache_inv_o, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    n_done = 0;
    exp_q.delete();
    @(negedge clk);
    check("post_reset_state", dbg_state, CSR_RDR_IDLE);
    check("post_reset_rvalid", bus.redirect_valid_o, 1'b0);

    for (int i = 0; i < 3; i++) run_seq(vecs[0]);
    check_count("count_three");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x00000000 expected 0x00000001");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/csr_redirect_ctrl.md
Name: csr_redirect_ctrl

Overview:
- Sits directly downstream of the CSR/exception stage.
- Consumes that stage's per-instruction exception code, CSR branch request and branch target.
- Sequences the resulting pipeline recovery: flush, optional I-cache invalidate for FENCE.I, then a valid/ready redirect handshake to fetch.
- Holds the pipeline stalled until recovery completes.

Parameters:
- FLUSH_CYCLES, 2: cycles flush_o stays asserted per event; legal range 1..15, elaboration error otherwise.
- PC_W, 32: width of PC and target buses.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- valid_i  in  1  E1 instruction valid this cycle
- pc_i  in  PC_W  PC of E1 instruction
- exception_i  in  `EXCEPTION_W  exception code from CSR stage; 0 = none
- csr_branch_i  in  1  CSR file requests trap/return redirect
- csr_target_i  in  PC_W  trap vector / xEPC target
- redirect_ready_i  in  1  fetch accepts redirect
- icache_inv_done_i  in  1  I-cache invalidate complete, level
- stall_o  out  1  hold upstream stages
- flush_o  out  1  kill younger in-flight instructions
- icache_inv_o  out  1  I-cache invalidate request, level
- redirect_valid_o  out  1  redirect offered to fetch
- redirect_pc_o  out  PC_W  redirect address
- trap_count_o  out  32  completed-redirect counter; see optional feature

Behaviour:
- Reset (rst_n==0 at posedge):
  - state <= IDLE; all outputs 0; redirect_pc_o 0; flush counter 0.
  - Reset mid-sequence abandons the sequence; no partial handshake survives.
- take_w = (state==IDLE) & valid_i & ((exception_i==`EXCEPTION_FENCE) | csr_branch_i).
- Capture, in IDLE on take_w:
  - If exception_i==`EXCEPTION_FENCE (priority over csr_branch_i): is_fence <= 1; redirect_pc_o <= pc_i+4 (mod 2^PC_W).
  - Else: is_fence <= 0; redirect_pc_o <= {csr_target_i[PC_W-1:2],2'b00}.
  - Flush counter <= FLUSH_CYCLES-1; state <= FLUSH.
- Stall: stall_o = take_w | (state!=IDLE), combinational. The event instruction's cycle is already stalled.
- FLUSH:
  - flush_o=1 (registered, high exactly FLUSH_CYCLES cycles starting cycle N+1 for capture at N).
  - Counter decrements each cycle; at 0 goes to INVAL if is_fence, else REDIRECT.
- INVAL:
  - icache_inv_o=1 every cycle in INVAL.
  - Exit to REDIRECT the cycle after icache_inv_done_i is sampled 1. If done is already high on entry, INVAL lasts exactly 1 cycle.
- REDIRECT:
  - redirect_valid_o=1; redirect_pc_o stable while valid & !ready.
  - On redirect_valid_o & redirect_ready_i, go to IDLE next cycle. Ready high on the first cycle gives a 1-cycle REDIRECT.
  - Ready arriving before valid is ignored.
- valid_i, exception_i and csr_branch_i are ignored outside IDLE; upstream is stalled, so nothing is lost.
- Back-to-back: a new event can be taken in the first IDLE cycle after the handshake.
- Minimum sequence from capture to IDLE, non-fence: FLUSH_CYCLES+1 cycles plus ready wait.
- Non-trap exceptions (exception_i!=0 without csr_branch_i, non-FENCE) produce no action.
- State encoding: IDLE=0, FLUSH=1, INVAL=2, REDIRECT=3, 2-bit.

Optional Feature:
- CSR_REDIRECT_TRAP_CNT_EN defined:
  - trap_count_o increments by 1 on each completed redirect handshake, fence included.
  - Wraps 0xFFFFFFFF->0; reset to 0.
- Not defined: trap_count_o tied to 32'h0 and no counter flops are built.

Decomposition:
- Shared package / riscv_defs.v: `EXCEPTION_W, `EXCEPTION_FENCE, the state localparams (CSR_RDR_IDLE/FLUSH/INVAL/REDIRECT).
- One sub-module, csr_flush_timer: loadable 4-bit down-counter with a load and zero flag, driving flush_o and the FLUSH exit.

Test Plan:
- Trap redirect, FLUSH_CYCLES=2: valid_i=1, csr_branch_i=1, csr_target_i=0x8000_0103, redirect_ready_i=1 -> flush_o high 2 cycles, then redirect_valid_o 1 cycle with redirect_pc_o=0x8000_0100, stall_o high from capture cycle through REDIRECT.
- FENCE: exception_i=`EXCEPTION_FENCE, pc_i=0x0000_1FFC, icache_inv_done_i raised 3 cycles into INVAL -> icache_inv_o high 3 cycles, then redirect_pc_o=0x0000_2000.
- Backpressure: redirect_ready_i low for 5 cycles -> redirect_valid_o high and redirect_pc_o constant for 6 cycles; fresh csr_branch_i during the wait is ignored.
- PC wrap: FENCE at pc_i=0xFFFF_FFFC -> redirect_pc_o=0x0000_0000.
- Reset mid-INVAL: rst_n=0 one cycle -> all outputs 0 next cycle, state IDLE; trap_count_o=0 with CSR_REDIRECT_TRAP_CNT_EN.
- Counter: 3 completed redirects -> trap_count_o=3 with macro, 0 without.
